// File: rtl/tartaruga_pkg.sv
// Shared types and constants for the tartaruga front end.
package tartaruga_pkg;

  typedef logic [31:0] bus32_t;
  typedef logic [31:0] instruction_t;

  // One decoded-bound entry: the fetch address and the word found there.
  typedef struct packed {
    bus32_t       pc;
    instruction_t instr;
  } fetch_entry_t;

  localparam bus32_t RESET_PC_DEFAULT = 32'h0000_0000;

  // Instruction addresses are always word aligned; low bits are dropped.
  function automatic bus32_t align_word(input bus32_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order queue of fetch entries between memory and decode.
// Flush wins over a push in the same cycle; a push into a full queue
// is only taken together with a pop.
module fetch_fifo
  import tartaruga_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t data_i,
  input  logic         pop_i,
  output fetch_entry_t data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Storage, pointers and occupancy; flush empties the queue outright.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited word
// requests, queues returned instructions and hands them to decode.
// Redirects flush the queue and drop responses still in flight.
// Optional macro FETCH_BYPASS_EN: an empty queue forwards a kept response
// straight to decode in the same cycle.
module fetch_stage
  import tartaruga_pkg::*;
#(
  parameter bus32_t      RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  output logic         imem_req_valid_o,
  input  logic         imem_req_ready_i,
  output bus32_t       imem_req_addr_o,
  input  logic         imem_rsp_valid_i,
  input  instruction_t imem_rsp_data_i,
  input  logic         redirect_i,
  input  bus32_t       redirect_pc_i,
  output logic         valid_o,
  input  logic         ready_i,
  output bus32_t       pc_o,
  output instruction_t instr_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  bus32_t       fetch_pc_q, fetch_pc_d;
  bus32_t       rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW:0]  credit_used;
  logic [CW:0]  in_flight;
  logic         req_accept;
  logic         rsp_keep;
  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t fifo_wdata;
  fetch_entry_t fifo_head;

  // A request may only go out if its response is guaranteed a queue slot.
  assign credit_used      = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign imem_req_valid_o = rstn_i & (credit_used < (CW + 1)'(FIFO_DEPTH));
  assign imem_req_addr_o  = fetch_pc_q;
  assign req_accept       = imem_req_valid_o & imem_req_ready_i;
  assign rsp_keep         = imem_rsp_valid_i & ~redirect_i & (drop_cnt_q == '0);
  assign fifo_wdata       = '{pc: rsp_pc_q, instr: imem_rsp_data_i};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (redirect_i),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // PC and counter next state; a redirect overrides everything else and
  // marks every request still in flight (including one accepted now) stale.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    in_flight     = {1'b0, outstanding_q} + {{CW{1'b0}}, req_accept};
    if (imem_rsp_valid_i && (in_flight != '0)) in_flight = in_flight - (CW + 1)'(1);
    outstanding_d = in_flight[CW-1:0];
    if (redirect_i) begin
      fetch_pc_d = align_word(redirect_pc_i);
      rsp_pc_d   = align_word(redirect_pc_i);
      drop_cnt_d = in_flight[CW-1:0];
    end else begin
      if (req_accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_keep) rsp_pc_d = rsp_pc_q + 32'd4;
      if (imem_rsp_valid_i && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  // Decode-side presentation, with the optional same-cycle forward path.
  always_comb begin
    fifo_push = rsp_keep;
    valid_o   = ~fifo_empty & ~redirect_i;
    pc_o      = fifo_head.pc;
    instr_o   = fifo_head.instr;
`ifdef FETCH_BYPASS_EN
    if (fifo_empty && rsp_keep) begin
      valid_o   = 1'b1;
      pc_o      = rsp_pc_q;
      instr_o   = imem_rsp_data_i;
      fifo_push = ~ready_i;
    end
`else
`endif
    fifo_pop = valid_o & ready_i & ~fifo_empty;
  end

  // State registers for the PCs and in-flight bookkeeping.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // A response with nothing outstanding means the memory broke protocol.
  rsp_has_request: assert property (@(posedge clk_i) disable iff (!rstn_i)
    imem_rsp_valid_i |-> (outstanding_q != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural memory answers requests
// after a configurable latency with instr = ~addr, expected decode entries
// are queued by each test and a monitor compares every handshake.
module tb_fetch_stage;
  import tartaruga_pkg::*;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  logic         clk = 1'b0;
  logic         rstn;
  logic         reqValid;
  logic         imemReqReady;
  bus32_t       reqAddr;
  logic         rspValid;
  instruction_t rspData;
  logic         redirect;
  bus32_t       redirectPc;
  logic         valid;
  logic         ready;
  bus32_t       pc;
  instruction_t instr;

  memReq_t      memQ[$];
  fetch_entry_t expQ[$];
  int           checks = 0;
  int           failures = 0;
  int           cycle = 0;
  int           memLatency = 1;

  fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .imem_req_valid_o (reqValid),
    .imem_req_ready_i (imemReqReady),
    .imem_req_addr_o  (reqAddr),
    .imem_rsp_valid_i (rspValid),
    .imem_rsp_data_i  (rspData),
    .redirect_i       (redirect),
    .redirect_pc_i    (redirectPc),
    .valid_o          (valid),
    .ready_i          (ready),
    .pc_o             (pc),
    .instr_o          (instr)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs at the falling edge, plays the memory, and
  // reports what the DUT showed in that cycle.
  task automatic applyStimulus(input bit dReady, input bit mReady, input bit redir, input logic [31:0] rpc,
                               output bit reqSeen, output bit accSeen, output bit hsSeen,
                               output logic [31:0] addrSeen);
    ready        = dReady;
    imemReqReady = mReady;
    redirect     = redir;
    redirectPc   = rpc;
    if (memQ.size() > 0 && memQ[0].due == cycle) begin
      rspValid = 1'b1;
      rspData  = ~memQ[0].addr;
      memQ.delete(0);
    end else begin
      rspValid = 1'b0;
      rspData  = '0;
    end
    #1;
    reqSeen  = reqValid;
    accSeen  = reqValid & mReady;
    hsSeen   = valid & dReady;
    addrSeen = reqAddr;
    if (accSeen) memQ.push_back('{addr: reqAddr, due: cycle + memLatency});
    @(negedge clk);
    cycle++;
  endtask

  // Keeps decode and memory ready until the wanted number of handshakes.
  task automatic runUntilHandshakes(input string name, input int wanted, input int budget);
    bit r, a, h;
    logic [31:0] ad;
    int hs = 0;
    for (int i = 0; i < budget && hs < wanted; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, r, a, h, ad);
      if (h) hs++;
    end
    checkOutput(name, 32'(hs), 32'(wanted));
  endtask

  // Resets DUT and memory together; optionally checks valid drops at once.
  task automatic applyReset(input bit checkDrop);
    rstn = 1'b0;
    #1;
    if (checkDrop) begin
      checkOutput("t6ValidDrop", {31'h0, valid}, 32'h0);
      checkOutput("t6PcDrop", pc, 32'h0);
    end
    rspValid     = 1'b0;
    redirect     = 1'b0;
    ready        = 1'b0;
    imemReqReady = 1'b0;
    memQ.delete();
    @(negedge clk);
    rstn  = 1'b1;
    cycle = 0;
  endtask

  // Monitor: every decode handshake pops the scoreboard and is compared.
  initial begin
    fetch_entry_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rstn && valid && ready) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpectedEntry: got pc %h expected no entry", pc);
        end else begin
          e = expQ.pop_front();
          checkOutput("pcOut", pc, e.pc);
          checkOutput("instrOut", instr, e.instr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit r, a, h;
    logic [31:0] ad;
    int acc;

    rstn = 1'b0; ready = 1'b0; imemReqReady = 1'b0; rspValid = 1'b0;
    rspData = '0; redirect = 1'b0; redirectPc = '0;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rstValid", {31'h0, valid}, 32'h0);
    checkOutput("rstPc", pc, 32'h0);
    checkOutput("rstInstr", instr, 32'h0);
    checkOutput("rstReqValid", {31'h0, reqValid}, 32'h0);
    checkOutput("rstReqAddr", reqAddr, 32'h0);
    rstn = 1'b1;
    cycle = 0;

    $display("[TB] test 1: streaming fetch");
    memLatency = 1;
    expQ.push_back('{pc: 32'h0, instr: 32'hFFFF_FFFF});
    expQ.push_back('{pc: 32'h4, instr: 32'hFFFF_FFFB});
    expQ.push_back('{pc: 32'h8, instr: 32'hFFFF_FFF7});
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, r, a, h, ad);
    checkOutput("t1FirstReqValid", {31'h0, r}, 32'h1);
    checkOutput("t1FirstReqAddr", ad, 32'h0);
    runUntilHandshakes("t1Handshakes", 3, 30);
    checkOutput("t1Drained", 32'(expQ.size()), 32'h0);

    $display("[TB] test 2: decode backpressure");
    applyReset(1'b0);
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, r, a, h, ad);
      if (a) acc++;
    end
    checkOutput("t2Requests", 32'(acc), 32'h2);
    checkOutput("t2ReqStalled", {31'h0, r}, 32'h0);
    expQ.push_back('{pc: 32'h0, instr: 32'hFFFF_FFFF});
    expQ.push_back('{pc: 32'h4, instr: 32'hFFFF_FFFB});
    expQ.push_back('{pc: 32'h8, instr: 32'hFFFF_FFF7});
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, r, a, h, ad);
    checkOutput("t2NoReqOnPop", {31'h0, r}, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, r, a, h, ad);
    checkOutput("t2ReqResumed", {31'h0, r}, 32'h1);
    checkOutput("t2ResumeAddr", ad, 32'h8);
    runUntilHandshakes("t2Handshakes", 1, 30);
    checkOutput("t2Drained", 32'(expQ.size()), 32'h0);

    $display("[TB] test 3: redirect with two requests outstanding");
    applyReset(1'b0);
    memLatency = 3;
    expQ.push_back('{pc: 32'h100, instr: 32'hFFFF_FEFF});
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, r, a, h, ad);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, r, a, h, ad);
    checkOutput("t3SecondReq", ad, 32'h4);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h100, r, a, h, ad);
    checkOutput("t3NoReqAtRedirect", {31'h0, a}, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, r, a, h, ad);
    checkOutput("t3ValidLow", {31'h0, h}, 32'h0);
    checkOutput("t3AddrAfterRedirect", ad, 32'h100);
    runUntilHandshakes("t3Handshakes", 1, 20);
    checkOutput("t3Drained", 32'(expQ.size()), 32'h0);

    $display("[TB] test 4: redirect with response and accept in same cycle");
    applyReset(1'b0);
    memLatency = 1;
    expQ.push_back('{pc: 32'h200, instr: 32'hFFFF_FDFF});
    expQ.push_back('{pc: 32'h204, instr: 32'hFFFF_FDFB});
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, r, a, h, ad);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h203, r, a, h, ad);
    checkOutput("t4AcceptInRedirect", {31'h0, a}, 32'h1);
    checkOutput("t4RspInRedirect", {31'h0, rspValid}, 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, r, a, h, ad);
    checkOutput("t4NewAddr", ad, 32'h200);
    checkOutput("t4NewReq", {31'h0, a}, 32'h1);
    runUntilHandshakes("t4Handshakes", 2, 20);
    checkOutput("t4Drained", 32'(expQ.size()), 32'h0);

    $display("[TB] test 5: memory stall");
    applyReset(1'b0);
    memLatency = 1;
    expQ.push_back('{pc: 32'h0, instr: 32'hFFFF_FFFF});
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, r, a, h, ad);
      checkOutput("t5ReqHeld", {31'h0, r}, 32'h1);
      checkOutput("t5AddrHeld", ad, 32'h0);
      checkOutput("t5NoOutput", {31'h0, h}, 32'h0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, r, a, h, ad);
    checkOutput("t5ResumeAccept", {31'h0, a}, 32'h1);
    checkOutput("t5ResumeAddr", ad, 32'h0);
    runUntilHandshakes("t5Handshakes", 1, 20);
    checkOutput("t5Drained", 32'(expQ.size()), 32'h0);

    $display("[TB] test 6: reset with a full queue");
    applyReset(1'b0);
    memLatency = 1;
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, r, a, h, ad);
    checkOutput("t6ValidBefore", {31'h0, valid}, 32'h1);
    checkOutput("t6HeadBefore", pc, 32'h0);
    applyReset(1'b1);
    expQ.push_back('{pc: 32'h0, instr: 32'hFFFF_FFFF});
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, r, a, h, ad);
    checkOutput("t6RestartValid", {31'h0, r}, 32'h1);
    checkOutput("t6RestartAddr", ad, 32'h0);
    runUntilHandshakes("t6Handshakes", 1, 20);
    checkOutput("t6Drained", 32'(expQ.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

- Instruction fetch stage directly upstream of the decoder.
- Owns the fetch PC and issues word requests to instruction memory.
- Buffers returned instructions in a small in-order queue and presents `{pc, instr}` to decode with a valid/ready handshake.
- Handles control-flow redirects from later stages by flushing the queue and discarding stale in-flight responses.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `FIFO_DEPTH`, default `2`: instruction queue entries; also the bound on outstanding requests. Must be ≥1.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rstn_i`  in  1  reset; one clock, asynchronous, active-low.
- `imem_req_valid_o`  out  1  request valid.
- `imem_req_ready_i`  in  1  memory accepts request.
- `imem_req_addr_o`  out  32 (`bus32_t`)  word-aligned fetch address.
- `imem_rsp_valid_i`  in  1  response valid. Responses are in order and cannot be back-pressured.
- `imem_rsp_data_i`  in  32 (`instruction_t`)  instruction word.
- `redirect_i`  in  1  flush and refetch.
- `redirect_pc_i`  in  32  new PC; bits [1:0] ignored (forced 0).
- `valid_o`  out  1  decode entry valid.
- `ready_i`  in  1  decode accepts.
- `pc_o`  out  32  PC of presented instruction.
- `instr_o`  out  32 (`instruction_t`)  presented instruction.

## Operation
State:
- `fetch_pc`: next request address.
- `rsp_pc`: PC of the next kept response.
- `outstanding` counter.
- `drop_cnt` counter.
- Queue of `fetch_entry_t`.

Request side:
- `imem_req_valid_o = (outstanding + occupancy < FIFO_DEPTH)`. This credit rule guarantees every response has a queue slot.
- `imem_req_addr_o = fetch_pc`.
- On accept (valid & ready): `fetch_pc += 4`, `outstanding++`.
- Once asserted, address and valid stay stable until accepted, except on redirect.

Response side:
- Each `imem_rsp_valid_i` decrements `outstanding`.
- If `drop_cnt > 0`: response is discarded and `drop_cnt--`.
- Otherwise: `{rsp_pc, data}` is pushed and `rsp_pc += 4`.

Output side:
- `valid_o = queue non-empty & ~redirect_i`.
- `pc_o` and `instr_o` come from the queue head.
- Pop on `valid_o & ready_i`.

Redirect (highest priority):
- Queue is flushed.
- `fetch_pc` and `rsp_pc` load `redirect_pc_i & ~3`.
- `drop_cnt` loads `outstanding + req_accept − rsp_valid`, evaluated for this cycle. A request accepted in the redirect cycle is therefore stale and dropped.
- A response arriving in the redirect cycle is discarded.

Other rules:
- Arithmetic: PC adds wrap modulo 2^32.
- Counters are `$clog2(FIFO_DEPTH+1)` bits.
- Response with `outstanding == 0` is a protocol error: simulation assertion, and the counter does not underflow.

## Timing
- Reset values: `valid_o=0`, `pc_o=0`, `instr_o=0`, `imem_req_valid_o=0`, `imem_req_addr_o=RESET_PC`.
  - Internal: `fetch_pc=rsp_pc=RESET_PC`, `outstanding=drop_cnt=0`, queue empty.
- First cycle after reset release: `imem_req_valid_o=1` at `RESET_PC`.
- Response in cycle N → `valid_o=1` in cycle N+1 (registered queue; see Configuration).
- Redirect in cycle N:
  - Cycle N+1: request at the new PC.
  - Cycle N+1: `valid_o=0` until the first kept response is queued.
- Queue full and `ready_i=0`: no requests are issued.
  - A pop frees a credit; request resumes the next cycle.
- Simultaneous push and pop when full: legal; occupancy is unchanged.
- Reset asserted mid-operation: all state clears immediately. Responses that arrive after reset release for pre-reset requests are not tracked; the memory must be reset together with this block.

## Configuration
Macro: `FETCH_BYPASS_EN`.
- **Defined:** when the queue is empty and a kept response arrives, `valid_o`, `pc_o` and `instr_o` are driven combinationally from the response in the same cycle.
  - If `ready_i=1`, the entry is consumed and not pushed.
  - Otherwise it is pushed as usual.
  - Fetch-to-decode latency is 0 cycles.
- **Undefined:** outputs come only from the queue; latency is 1 cycle and there is no combinational memory-to-decode path.

## Structure
- `tartaruga_pkg` gets:
  - `fetch_entry_t` (`bus32_t pc`, `instruction_t instr`).
  - `RESET_PC_DEFAULT` constant.
- Sub-module `fetch_fifo`:
  - Parameterised depth; element type `fetch_entry_t`.
  - Ports: push, pop, flush, full, empty, `count`.
  - Flush has priority over push in the same cycle.
- `fetch_stage` holds the PC registers, counters, credit logic and bypass mux.
- Output connects to the decoder's `pc_i`/`instr_i` via the decode pipeline register.

## Test plan
- **Reset, always-ready memory (1-cycle response), `ready_i=1`:** requests 0x0, 0x4, 0x8; decode sees `pc_o` 0x0, 0x4, 0x8 with matching instructions, one per cycle after fill.
- **Backpressure, `ready_i=0` for 10 cycles, `FIFO_DEPTH=2`:** exactly 2 requests issued, then `imem_req_valid_o=0`. On `ready_i=1`, entries drain in order with no loss or duplication.
- **Redirect to 0x100 with 2 requests outstanding:** both responses discarded; next `valid_o` carries `pc_o=0x100`.
- **Redirect to 0x203 in the same cycle as a response and a request accept:** both stale responses dropped; first presented `pc_o=0x200`.
- **Memory stalls `imem_req_ready_i=0` for 5 cycles:** address held stable; no responses expected; fetch resumes at the same address.
- **Reset asserted while queue is full:** `valid_o` drops immediately; after release, fetch restarts at `RESET_PC`.
